// File: rtl/div16by8_seq.sv
`default_nettype none
// ============================================================================
// Module      : div16by8_seq
// Description : Sequential signed 16/8 restoring divider with 8-bit results.
// Revision    : 1.0 - initial release
// ============================================================================
module div16by8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  out_q,
    output logic [7:0]  out_r,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        ovf
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CHECK = 3'd1;
    localparam logic [2:0] c_ITER  = 3'd2;
    localparam logic [2:0] c_FIX   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [15:0] r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_abs_b;
    logic [7:0]  r_rem;
    logic [7:0]  r_lo;
    logic        r_neg_a;
    logic        r_neg_b;
    logic [2:0]  r_cnt;
    logic [7:0]  r_q;
    logic [7:0]  r_r;
    logic        r_div_zero;
    logic        r_ovf;

    logic        w_accept;
    logic [15:0] w_abs_a;
    logic [7:0]  w_abs_b;
    logic        w_err_zero;
    logic        w_err_ovf;
    logic [8:0]  w_trial;
    logic        w_fits;
    logic [7:0]  w_sub;
    logic        w_sign_diff;
    logic        w_q_ovf;
    logic [7:0]  w_q_fix;
    logic [7:0]  w_r_fix;

    assign busy     = (r_state == c_CHECK) || (r_state == c_ITER) || (r_state == c_FIX);
    assign done     = (r_state == c_DONE);
    assign out_q    = r_q;
    assign out_r    = r_r;
    assign div_zero = r_div_zero;
    assign ovf      = r_ovf;

    assign w_accept   = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_abs_a    = r_a[15] ? (~r_a + 16'd1) : r_a;
    assign w_abs_b    = r_b[7]  ? (~r_b + 8'd1)  : r_b;
    assign w_err_zero = (r_b == 8'd0);
    // A high byte not below the divisor means the magnitude quotient needs more than 8 bits
    assign w_err_ovf  = (w_abs_a[15:8] >= w_abs_b);

    // Partial remainder always stays below |b| <= 0x80, so 8 bits hold it between steps
    assign w_trial = {r_rem, r_lo[7]};
    assign w_fits  = (w_trial >= {1'b0, r_abs_b});
    assign w_sub   = w_trial[7:0] - r_abs_b;

    assign w_sign_diff = r_neg_a ^ r_neg_b;
    assign w_q_ovf     = w_sign_diff ? (r_lo > 8'd128) : (r_lo > 8'd127);
    assign w_q_fix     = w_sign_diff ? (~r_lo + 8'd1) : r_lo;
    assign w_r_fix     = r_neg_a ? (~r_rem + 8'd1) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_CHECK;
            c_CHECK: w_next_state = (w_err_zero || w_err_ovf) ? c_DONE : c_ITER;
            c_ITER:  if (r_cnt == 3'd7) w_next_state = c_FIX;
            c_FIX:   w_next_state = c_DONE;
            c_DONE:  w_next_state = start ? c_CHECK : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= 16'd0;
            r_b        <= 8'd0;
            r_abs_b    <= 8'd0;
            r_rem      <= 8'd0;
            r_lo       <= 8'd0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_cnt      <= 3'd0;
            r_q        <= 8'd0;
            r_r        <= 8'd0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
            end
            case (r_state)
                c_CHECK: begin
                    r_abs_b <= w_abs_b;
                    r_rem   <= w_abs_a[15:8];
                    r_lo    <= w_abs_a[7:0];
                    r_neg_a <= r_a[15];
                    r_neg_b <= r_b[7];
                    r_cnt   <= 3'd0;
                    if (w_err_zero || w_err_ovf) begin
                        r_q        <= 8'd0;
                        r_r        <= 8'd0;
                        r_div_zero <= w_err_zero;
                        r_ovf      <= !w_err_zero;
                    end
                end
                c_ITER: begin
                    r_rem <= w_fits ? w_sub : w_trial[7:0];
                    r_lo  <= {r_lo[6:0], w_fits};
                    r_cnt <= r_cnt + 3'd1;
                end
                c_FIX: begin
                    r_div_zero <= 1'b0;
                    r_ovf      <= w_q_ovf;
                    r_q        <= w_q_ovf ? 8'd0 : w_q_fix;
                    r_r        <= w_q_ovf ? 8'd0 : w_r_fix;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div16by8_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div16by8_seq
// Description : Randomized self-checking bench for div16by8_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div16by8_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_a;
    logic [7:0]  in_b;
    logic [7:0]  out_q;
    logic [7:0]  out_r;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        ovf;

    int          n_checks;
    int          n_errors;
    logic [7:0]  prev_q;
    logic [7:0]  prev_r;

    div16by8_seq u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_q    (out_q),
        .out_r    (out_r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: signed integer division, result range and the high-byte precheck
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
        int sa, sb, aa, ab, qi, ri;
        sa = $signed(a);
        sb = $signed(b);
        q = 8'd0; r = 8'd0; dz = 1'b0; ov = 1'b0; lat = 10;
        if (sb == 0) begin
            dz = 1'b1;
            lat = 1;
        end else begin
            aa = (sa < 0) ? -sa : sa;
            ab = (sb < 0) ? -sb : sb;
            if ((aa / 256) >= ab) begin
                ov = 1'b1;
                lat = 1;
            end else begin
                qi = sa / sb;
                ri = sa % sb;
                if (qi > 127 || qi < -128) begin
                    ov = 1'b1;
                end else begin
                    q = qi[7:0];
                    r = ri[7:0];
                end
            end
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [7:0] b);
        start = 1'b1;
        in_a  = a;
        in_b  = b;
    endtask

    // Call with start already raised; returns just after the done cycle is sampled
    task automatic finish_op(input logic [15:0] a, input logic [7:0] b, input bit chain,
                             input logic [15:0] na, input logic [7:0] nb);
        logic [7:0] eq, er;
        logic       edz, eov;
        int         elat, lat;
        model(a, b, eq, er, edz, eov, elat);
        @(posedge clk); #1;
        start = 1'b0;
        in_a  = 16'($urandom);
        in_b  = 8'($urandom);
        check("busy_after_accept", busy, 1);
        check("done_low_after_accept", done, 0);
        check("hold_q_during_busy", out_q, prev_q);
        check("hold_r_during_busy", out_r, prev_r);
        lat = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            start = 1'($urandom);
            in_a  = 16'($urandom);
            in_b  = 8'($urandom);
        end
        start = 1'b0;
        check("done_latency", lat, elat);
        check("out_q", out_q, eq);
        check("out_r", out_r, er);
        check("div_zero", div_zero, edz);
        check("ovf", ovf, eov);
        check("busy_in_done", busy, 0);
        prev_q = eq;
        prev_r = er;
        if (chain) launch(na, nb);
    endtask

    task automatic single(input logic [15:0] a, input logic [7:0] b);
        launch(a, b);
        finish_op(a, b, 1'b0, 16'd0, 8'd0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    logic [15:0] ta [14];
    logic [7:0]  tb_ [14];
    logic [15:0] ra;
    logic [7:0]  rb;
    int          seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        prev_q = 8'd0;
        prev_r = 8'd0;
        rst = 1'b1;
        start = 1'b1;
        in_a = 16'h0064;
        in_b = 8'h07;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", out_q, 0);
        check("rst_r", out_r, 0);
        check("rst_dz", div_zero, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        ta[0]  = 16'h0064; tb_[0]  = 8'h07;
        ta[1]  = 16'hFF9C; tb_[1]  = 8'h07;
        ta[2]  = 16'h0064; tb_[2]  = 8'hF9;
        ta[3]  = 16'hFF9C; tb_[3]  = 8'hF9;
        ta[4]  = 16'h1234; tb_[4]  = 8'h00;
        ta[5]  = 16'h0400; tb_[5]  = 8'h02;
        ta[6]  = 16'h8000; tb_[6]  = 8'h80;
        ta[7]  = 16'hFF00; tb_[7]  = 8'h02;
        ta[8]  = 16'h0100; tb_[8]  = 8'h02;
        ta[9]  = 16'h7FFF; tb_[9]  = 8'h7F;
        ta[10] = 16'h3F80; tb_[10] = 8'h7F;
        ta[11] = 16'h3F01; tb_[11] = 8'h7F;
        ta[12] = 16'h7F80; tb_[12] = 8'h80;
        ta[13] = 16'h0000; tb_[13] = 8'hFF;
        for (int i = 0; i < 14; i++) single(ta[i], tb_[i]);

        // Back-to-back: start held in the DONE cycle
        launch(16'h0064, 8'h07);
        finish_op(16'h0064, 8'h07, 1'b1, 16'hFF9C, 8'hF9);
        finish_op(16'hFF9C, 8'hF9, 1'b1, 16'h0000, 8'h00);
        finish_op(16'h0000, 8'h00, 1'b0, 16'd0, 8'd0);
        @(posedge clk); #1;

        // Reset in the fourth ITER cycle aborts the operation
        launch(16'h1234, 8'h56);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_q", out_q, 0);
        check("abort_r", out_r, 0);
        check("abort_dz", div_zero, 0);
        check("abort_ovf", ovf, 0);
        prev_q = 8'd0;
        prev_r = 8'd0;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        single(16'h1234, 8'h56);

        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom) >> $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) ra = ~ra + 16'd1;
            rb = 8'($urandom);
            if ($urandom_range(0, 9) == 0) rb = 8'd0;
            if ($urandom_range(0, 2) == 0) begin
                launch(ra, rb);
                finish_op(ra, rb, 1'b1, ~ra, rb ^ 8'h40);
                finish_op(~ra, rb ^ 8'h40, 1'b0, 16'd0, 8'd0);
                @(posedge clk); #1;
                check("done_one_cycle", done, 0);
            end else begin
                single(ra, rb);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
